// File: rtl/mem_probe_ctrl.sv
// Purpose : board probe controller; debounced buttons freeze the processor, step a probe address, show the word in hex.
// Latency : button accept DEBOUNCE_CYCLES+3 cycles to FSM effect; word captured READ_LAT cycles after hld/addr change.
// Backpr. : none; buttons are level-debounced, and same-cycle presses resolve hold > load > inc > dec, dropping the rest.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   btn_hold/inc/dec/load     raw push buttons (synchronized and debounced internally)
//   sw_addr[13:0]             address loaded by btn_load
//   mem_data[15:0]            word returned by the processor wrapper
//   hld, addr[13:0]           freeze request and probe address to the wrapper
//   data_vld, shown[15:0]     captured word and its validity for the current addr
//   seg[6:0], an[3:0]         active-low 7-segment segments {g..a} and digit enables

// Single button path: two-flop synchronizer, debounce counter and rising-edge pulse.
module mem_probe_btn #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          acc_q, acc_d;
    logic          acc_dly_q;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = '0;
        acc_d   = acc_q;
        // Count only while the synchronized level disagrees with the accepted one;
        // the final count is folded into the accept so the counter never exceeds N-1.
        if (sync2_q != acc_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                acc_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        pulse_d = acc_q & ~acc_dly_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            acc_q     <= 1'b0;
            acc_dly_q <= 1'b0;
            cnt_q     <= '0;
            pulse_q   <= 1'b0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            acc_q     <= acc_d;
            acc_dly_q <= acc_q;
            cnt_q     <= cnt_d;
            pulse_q   <= pulse_d;
        end
    end

    assign pulse = pulse_q;
endmodule

module mem_probe_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int READ_LAT        = 2,
    parameter int REFRESH_DIV     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_hold,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_load,
    input  logic [13:0] sw_addr,
    input  logic [15:0] mem_data,
    output logic        hld,
    output logic [13:0] addr,
    output logic        data_vld,
    output logic [15:0] shown,
    output logic [6:0]  seg,
    output logic [3:0]  an
);
    localparam int LW = (READ_LAT > 1)    ? $clog2(READ_LAT)    : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {S_RUN, S_SETTLE, S_SHOW} state_t;

    logic hold_p, inc_p, dec_p, load_p;

    mem_probe_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_hold (.clk(clk), .rst(rst), .raw(btn_hold), .pulse(hold_p));
    mem_probe_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_inc  (.clk(clk), .rst(rst), .raw(btn_inc),  .pulse(inc_p));
    mem_probe_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_dec  (.clk(clk), .rst(rst), .raw(btn_dec),  .pulse(dec_p));
    mem_probe_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_load (.clk(clk), .rst(rst), .raw(btn_load), .pulse(load_p));

    state_t        state_q, state_d;
    logic [13:0]   addr_q, addr_d;
    logic [15:0]   shown_q, shown_d;
    logic          vld_q, vld_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [RW-1:0] ref_q, ref_d;
    logic [1:0]    dig_q, dig_d;
    logic          step;
    logic [3:0]    nib;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            addr_q  <= '0;
            shown_q <= '0;
            vld_q   <= 1'b0;
            lat_q   <= '0;
            ref_q   <= '0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            shown_q <= shown_d;
            vld_q   <= vld_d;
            lat_q   <= lat_d;
            ref_q   <= ref_d;
            dig_q   <= dig_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        shown_d = shown_q;
        vld_d   = vld_q;
        lat_d   = lat_q;
        step    = load_p | inc_p | dec_p;

        case (state_q)
            S_RUN: begin
                if (hold_p) begin
                    state_d = S_SETTLE;
                    lat_d   = '0;
                end
            end
            S_SETTLE, S_SHOW: begin
                if (hold_p) begin
                    state_d = S_RUN;
                    vld_d   = 1'b0;
                end else if (step) begin
                    // An address step restarts the settle window even mid-settle.
                    if (load_p)     addr_d = sw_addr;
                    else if (inc_p) addr_d = addr_q + 14'd1;
                    else            addr_d = addr_q - 14'd1;
                    vld_d   = 1'b0;
                    lat_d   = '0;
                    state_d = S_SETTLE;
                end else if (state_q == S_SETTLE) begin
                    if (lat_q == LW'(READ_LAT - 1)) begin
                        shown_d = mem_data;
                        vld_d   = 1'b1;
                        state_d = S_SHOW;
                    end else begin
                        lat_d = lat_q + LW'(1);
                    end
                end
            end
            default: state_d = S_RUN;
        endcase

        // Display scan runs regardless of state so the digit phase is continuous.
        if (ref_q == RW'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            dig_d = dig_q + 2'd1;
        end else begin
            ref_d = ref_q + RW'(1);
            dig_d = dig_q;
        end
    end

    // Outputs.
    always_comb begin
        hld = (state_q != S_RUN);
        an  = 4'b1111;
        seg = 7'b1111111;
        nib = shown_q[{dig_q, 2'b00} +: 4];
        if (state_q == S_SHOW) begin
            an = ~(4'b0001 << dig_q);
            case (nib)
                4'h0: seg = 7'b1000000;
                4'h1: seg = 7'b1111001;
                4'h2: seg = 7'b0100100;
                4'h3: seg = 7'b0110000;
                4'h4: seg = 7'b0011001;
                4'h5: seg = 7'b0010010;
                4'h6: seg = 7'b0000010;
                4'h7: seg = 7'b1111000;
                4'h8: seg = 7'b0000000;
                4'h9: seg = 7'b0010000;
                4'hA: seg = 7'b0001000;
                4'hB: seg = 7'b0000011;
                4'hC: seg = 7'b1000110;
                4'hD: seg = 7'b0100001;
                4'hE: seg = 7'b0000110;
                default: seg = 7'b0001110;
            endcase
        end
    end

    assign addr     = addr_q;
    assign shown    = shown_q;
    assign data_vld = vld_q;
endmodule

// File: tb/tb_mem_probe_ctrl.sv
module tb_mem_probe_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_hold = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_load = 1'b0;
    logic [13:0] sw_addr = '0;
    logic [15:0] mem_data = '0;
    logic        hld;
    logic [13:0] addr;
    logic        data_vld;
    logic [15:0] shown;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_probe_ctrl #(.DEBOUNCE_CYCLES(16), .READ_LAT(2), .REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst),
        .btn_hold(btn_hold), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_load(btn_load),
        .sw_addr(sw_addr), .mem_data(mem_data),
        .hld(hld), .addr(addr), .data_vld(data_vld), .shown(shown),
        .seg(seg), .an(an)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // 0 hold, 1 inc, 2 dec, 3 load
    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0: btn_hold = v;
            1: btn_inc  = v;
            2: btn_dec  = v;
            default: btn_load = v;
        endcase
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b0;
        btn_hold = 1'b1; btn_inc = 1'b1; btn_dec = 1'b1; btn_load = 1'b1;
        tick(3);
        checks++; if (hld !== 1'b0)          begin failures++; $display("FAIL rst_hld got %b want 0", hld); end
        checks++; if (addr !== 14'h0)        begin failures++; $display("FAIL rst_addr got %h want 0", addr); end
        checks++; if (data_vld !== 1'b0)     begin failures++; $display("FAIL rst_vld got %b want 0", data_vld); end
        checks++; if (shown !== 16'h0)       begin failures++; $display("FAIL rst_shown got %h want 0", shown); end
        checks++; if (an !== 4'b1111)        begin failures++; $display("FAIL rst_an got %b want 1111", an); end
        checks++; if (seg !== 7'b1111111)    begin failures++; $display("FAIL rst_seg got %b want 1111111", seg); end
        btn_hold = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_load = 1'b0;
        rst = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (hld !== 1'b0 || addr !== 14'h0 || data_vld !== 1'b0 || an !== 4'b1111 || seg !== 7'b1111111)
                ok = 1'b0;
        end
        checks++; if (!ok) begin failures++; $display("FAIL rst_idle got hld=%b addr=%h vld=%b want idle", hld, addr, data_vld); end
    endtask

    task automatic test_hold_entry();
        int t;
        mem_data = 16'hBEEF;
        btn_hold = 1'b1;
        tick(19);
        checks++; if (hld !== 1'b0)       begin failures++; $display("FAIL hold_early got %b want 0", hld); end
        tick(1);
        checks++; if (hld !== 1'b1)       begin failures++; $display("FAIL hold_entry got %b want 1", hld); end
        checks++; if (data_vld !== 1'b0)  begin failures++; $display("FAIL hold_vld0 got %b want 0", data_vld); end
        tick(1);
        checks++; if (data_vld !== 1'b0)  begin failures++; $display("FAIL hold_vld1 got %b want 0", data_vld); end
        tick(1);
        checks++; if (data_vld !== 1'b1)  begin failures++; $display("FAIL hold_vld2 got %b want 1", data_vld); end
        checks++; if (shown !== 16'hBEEF) begin failures++; $display("FAIL hold_shown got %h want beef", shown); end
        btn_hold = 1'b0;
        t = 0;
        while (an !== 4'b0111 && t < 40) begin tick(1); t++; end
        checks++; if (an !== 4'b0111) begin failures++; $display("FAIL disp_sync3 got %b want 0111", an); end
        t = 0;
        while (an !== 4'b1110 && t < 8) begin tick(1); t++; end
        checks++; if (an !== 4'b1110)     begin failures++; $display("FAIL disp_sync0 got %b want 1110", an); end
        checks++; if (seg !== 7'b0001110) begin failures++; $display("FAIL disp_seg0 got %b want 0001110", seg); end
        tick(3);
        checks++; if (an !== 4'b1110)     begin failures++; $display("FAIL disp_hold0 got %b want 1110", an); end
        tick(1);
        checks++; if (an !== 4'b1101)     begin failures++; $display("FAIL disp_an1 got %b want 1101", an); end
        checks++; if (seg !== 7'b0000110) begin failures++; $display("FAIL disp_seg1 got %b want 0000110", seg); end
        tick(4);
        checks++; if (an !== 4'b1011)     begin failures++; $display("FAIL disp_an2 got %b want 1011", an); end
        checks++; if (seg !== 7'b0000110) begin failures++; $display("FAIL disp_seg2 got %b want 0000110", seg); end
        tick(4);
        checks++; if (an !== 4'b0111)     begin failures++; $display("FAIL disp_an3 got %b want 0111", an); end
        checks++; if (seg !== 7'b0000011) begin failures++; $display("FAIL disp_seg3 got %b want 0000011", seg); end
        tick(4);
        checks++; if (an !== 4'b1110)     begin failures++; $display("FAIL disp_wrap got %b want 1110", an); end
        tick(20);
    endtask

    task automatic test_wrap();
        int          kind [3]  = '{3, 1, 2};
        logic [13:0] exp_a [3] = '{14'h3FFF, 14'h0000, 14'h3FFF};
        logic [15:0] mdat [3]  = '{16'h1111, 16'h2222, 16'h3333};
        sw_addr = 14'h3FFF;
        for (int i = 0; i < 3; i++) begin
            mem_data = mdat[i];
            set_btn(kind[i], 1'b1);
            tick(20);
            checks++; if (addr !== exp_a[i]) begin failures++; $display("FAIL wrap_addr%0d got %h want %h", i, addr, exp_a[i]); end
            checks++; if (data_vld !== 1'b0) begin failures++; $display("FAIL wrap_vldA%0d got %b want 0", i, data_vld); end
            checks++; if (hld !== 1'b1)      begin failures++; $display("FAIL wrap_hld%0d got %b want 1", i, hld); end
            tick(1);
            checks++; if (data_vld !== 1'b0) begin failures++; $display("FAIL wrap_vldB%0d got %b want 0", i, data_vld); end
            tick(1);
            checks++; if (data_vld !== 1'b1) begin failures++; $display("FAIL wrap_vldC%0d got %b want 1", i, data_vld); end
            checks++; if (shown !== mdat[i]) begin failures++; $display("FAIL wrap_shown%0d got %h want %h", i, shown, mdat[i]); end
            set_btn(kind[i], 1'b0);
            tick(20);
        end
    endtask

    task automatic test_debounce();
        bit ok;
        mem_data = 16'hDEAD;
        btn_inc = 1'b1;
        tick(10);
        btn_inc = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (hld !== 1'b1 || data_vld !== 1'b1 || addr !== 14'h3FFF) ok = 1'b0;
        end
        checks++; if (!ok) begin failures++; $display("FAIL glitch_stable got addr=%h vld=%b want 3fff 1", addr, data_vld); end
        checks++; if (shown !== 16'h3333) begin failures++; $display("FAIL glitch_shown got %h want 3333", shown); end
    endtask

    task automatic test_simultaneous();
        btn_hold = 1'b1;
        btn_inc  = 1'b1;
        tick(19);
        checks++; if (hld !== 1'b1)       begin failures++; $display("FAIL simul_early got %b want 1", hld); end
        tick(1);
        checks++; if (hld !== 1'b0)       begin failures++; $display("FAIL simul_hld got %b want 0", hld); end
        checks++; if (addr !== 14'h3FFF)  begin failures++; $display("FAIL simul_addr got %h want 3fff", addr); end
        checks++; if (data_vld !== 1'b0)  begin failures++; $display("FAIL simul_vld got %b want 0", data_vld); end
        checks++; if (an !== 4'b1111)     begin failures++; $display("FAIL simul_an got %b want 1111", an); end
        checks++; if (seg !== 7'b1111111) begin failures++; $display("FAIL simul_seg got %b want 1111111", seg); end
        checks++; if (shown !== 16'h3333) begin failures++; $display("FAIL simul_shown got %h want 3333", shown); end
        btn_hold = 1'b0;
        btn_inc  = 1'b0;
        tick(20);
    endtask

    task automatic test_run_ignore();
        int kind [3] = '{1, 2, 3};
        sw_addr = 14'h0123;
        for (int i = 0; i < 3; i++) begin
            set_btn(kind[i], 1'b1);
            tick(25);
            checks++; if (addr !== 14'h3FFF || hld !== 1'b0)
                begin failures++; $display("FAIL run_ignore%0d got addr=%h hld=%b want 3fff 0", i, addr, hld); end
            set_btn(kind[i], 1'b0);
            tick(20);
        end
    endtask

    task automatic test_reset_mid();
        mem_data = 16'h5A5A;
        btn_hold = 1'b1;
        tick(22);
        checks++; if (data_vld !== 1'b1 || shown !== 16'h5A5A)
            begin failures++; $display("FAIL mid_show got vld=%b shown=%h want 1 5a5a", data_vld, shown); end
        btn_hold = 1'b0;
        tick(20);
        sw_addr = 14'h0042;
        btn_load = 1'b1;
        tick(20);
        checks++; if (addr !== 14'h0042 || hld !== 1'b1 || data_vld !== 1'b0)
            begin failures++; $display("FAIL mid_settle got addr=%h hld=%b vld=%b want 0042 1 0", addr, hld, data_vld); end
        btn_load = 1'b0;
        tick(1);
        rst = 1'b0;
        #1;
        checks++; if (addr !== 14'h0)     begin failures++; $display("FAIL mid_addr got %h want 0", addr); end
        checks++; if (hld !== 1'b0)       begin failures++; $display("FAIL mid_hld got %b want 0", hld); end
        checks++; if (data_vld !== 1'b0)  begin failures++; $display("FAIL mid_vld got %b want 0", data_vld); end
        checks++; if (shown !== 16'h0)    begin failures++; $display("FAIL mid_shown got %h want 0", shown); end
        mem_data = 16'hFFFF;
        tick(3);
        checks++; if (shown !== 16'h0 || data_vld !== 1'b0)
            begin failures++; $display("FAIL mid_nocap got shown=%h vld=%b want 0 0", shown, data_vld); end
        rst = 1'b1;
        tick(5);
        checks++; if (hld !== 1'b0 || shown !== 16'h0 || an !== 4'b1111)
            begin failures++; $display("FAIL mid_after got hld=%b shown=%h an=%b want 0 0 1111", hld, shown, an); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_hold_entry();
        test_wrap();
        test_debounce();
        test_simultaneous();
        test_run_ignore();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_probe_ctrl.md
# mem_probe_ctrl

Board-side probe controller that sits directly upstream of the processor wrapper and drives its `hld` and `addr` inputs. It also consumes the wrapper's 16-bit `out` data. The block debounces user buttons and freezes the processor on request. It steps a 14-bit probe address, captures the returned memory word after a fixed settle latency, and shows the word in hex on a multiplexed 4-digit 7-segment display.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles needed before a button level is accepted (≥2).
- `READ_LAT`, 2: cycles from an `addr`/`hld` change until `mem_data` is valid (≥1).
- `REFRESH_DIV`, 4: clock cycles each display digit stays lit (≥1).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `btn_hold`  in  1  raw button; each press toggles hold mode.
- `btn_inc`  in  1  raw button; probe address +1.
- `btn_dec`  in  1  raw button; probe address −1.
- `btn_load`  in  1  raw button; load `sw_addr` into the probe address.
- `sw_addr`  in  14  switch value used by load.
- `mem_data`  in  16  wrapper `out`.
- `hld`  out  1  to wrapper `hld`.
- `addr`  out  14  to wrapper `addr`.
- `data_vld`  out  1  high while `shown` holds the word at the current `addr`.
- `shown`  out  16  captured word.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `an`  out  4  digit enables, active-low; `an[0]` is the least-significant hex digit.

## Operation
- Each button path:
  - Two-flop synchronizer.
  - Debounce counter: counts while the synchronized level ≠ the accepted level, and clears to 0 when the two are equal. When the count reaches `DEBOUNCE_CYCLES`, the accepted level takes the synchronized level.
  - A rising edge of the accepted level makes a registered 1-cycle pulse. Releases do nothing.
- FSM states:
  - **RUN**: `hld`=0; display blank. A hold pulse → SETTLE: `hld`←1, latency counter←0. `addr` is unchanged.
  - **SETTLE**: `hld`=1; latency counter increments every cycle. When the counter = `READ_LAT`−1: `shown`←`mem_data`, `data_vld`←1, → SHOW.
  - **SHOW**: `hld`=1; display active.
    - Inc → `addr`+1, mod 2^14.
    - Dec → `addr`−1, mod 2^14.
    - Load → `addr`←`sw_addr`.
    - Each of these sets `data_vld`←0, clears the latency counter and → SETTLE.
  - Hold pulse in SETTLE or SHOW → RUN: `hld`←0, `data_vld`←0. `shown` and `addr` are retained.
- Pulses on the same cycle are resolved with priority hold > load > inc > dec, and lower-priority pulses are dropped.
- Inc, dec and load pulses in RUN are ignored.
- Inc, dec and load pulses in SETTLE are applied: the address updates and the latency counter restarts.
- Display:
  - Refresh counter runs 0..`REFRESH_DIV`−1. On wrap, the digit index advances 0→1→2→3→0.
  - Digit i shows `shown[4i+3:4i]`; `an` has only bit i low.
  - Display is blank (`an`=4'b1111, `seg`=7'b1111111) outside SHOW. The refresh counter keeps running while blank.
  - Hex encoding:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000
    - 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011
    - C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- Reset values, applied immediately while `rst`=0:
  - State RUN.
  - `hld`=0, `addr`=0, `shown`=0, `data_vld`=0.
  - `an`=4'b1111, `seg`=7'b1111111.
  - All counters, synchronizers and accepted levels are 0; no pulse is emitted on release from reset.
- Button latency: with the raw input high and stable from clock edge k onward, the pulse is high during cycle k+`DEBOUNCE_CYCLES`+2. The FSM registers the effect at edge k+`DEBOUNCE_CYCLES`+3.
- Capture latency: `shown` and `data_vld` update exactly `READ_LAT` edges after the edge that set `hld`=1 or changed `addr`.
- A raw glitch shorter than `DEBOUNCE_CYCLES` cycles produces no pulse.
- Reset asserted mid-SETTLE or mid-SHOW aborts at once to the reset values, with no capture.

## Test plan
- Reset: hold `rst`=0 for 3 cycles while pressing every button, then release → all outputs at reset values; no state change for 40 cycles.
- Hold entry (DEBOUNCE=16, READ_LAT=2, `mem_data`=16'hBEEF):
  - Press `btn_hold` → `hld`=1 at edge k+19.
  - `shown`=16'hBEEF and `data_vld`=1 two edges later.
  - `an` then cycles 1110, 1101, 1011, 0111 every 4 clocks, and `seg`=0001110 (F) on digit 0.
- Wrap: load `sw_addr`=14'h3FFF, then inc → `addr`=0. Dec → `addr`=14'h3FFF. `data_vld` drops for 2 cycles after each step.
- Debounce: a 10-cycle `btn_inc` glitch in SHOW → `addr` unchanged and no SETTLE entered.
- Simultaneous: `btn_hold` and `btn_inc` debounced on the same cycle in SHOW → RUN, `hld`=0, `addr` unchanged.
- Reset mid-operation: assert `rst`=0 one cycle into SETTLE with `addr`=14'h0042 → `addr`=0, `hld`=0, `data_vld`=0 immediately, with no capture.
